// File: rtl/ult_pkg.sv
// Shared types and default timing constants for the ultrasonic echo ranger.
package ult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TRIG = 3'd1,
        ST_WAIT = 3'd2,
        ST_MEAS = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int TRIG_CYCLES_DEF    = 120;
    localparam int PERIOD_CYCLES_DEF  = 720000;
    localparam int CYCLES_PER_MM_DEF  = 70;
    localparam int TIMEOUT_CYCLES_DEF = 360000;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Single-digit BCD increment with carry out.
    function automatic logic [4:0] bcd_digit_inc(input bcd_t d);
        logic [4:0] r;
        if (d == 4'd9) begin
            r = {1'b1, 4'd0};
        end else begin
            r = {1'b0, d + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd4_counter.sv
// Four cascaded BCD digits with synchronous clear and increment, saturating at 9999.
module bcd4_counter
    import ult_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value
);

    logic [15:0] value_r;
    logic [15:0] next_s;
    logic        sat_s;

    assign sat_s = (value_r == BCD_MAX);
    assign value = value_r;

    // Ripple the increment through the digits, carrying only out of a 9.
    always_comb begin
        logic       carry;
        logic [4:0] step;
        next_s = value_r;
        carry  = 1'b1;
        step   = 5'd0;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                step              = bcd_digit_inc(value_r[i*4 +: 4]);
                next_s[i*4 +: 4]  = step[3:0];
                carry             = step[4];
            end else begin
                next_s[i*4 +: 4]  = value_r[i*4 +: 4];
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value_r <= 16'h0000;
        end else if (clr) begin
            value_r <= 16'h0000;
        end else if (inc && !sat_s) begin
            value_r <= next_s;
        end else begin
            value_r <= value_r;
        end
    end

endmodule

// File: rtl/ult_echo_ranger.sv
// Ultrasonic ranger: periodic trigger, echo pulse timing, BCD millimetre result.
// Optional timeout on missing/overlong echo enabled by defining ULT_TIMEOUT_EN.
module ult_echo_ranger
    import ult_pkg::*;
#(
    parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
    parameter int PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
    parameter int CYCLES_PER_MM  = CYCLES_PER_MM_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       echo,
    output logic       trig,
    output logic [3:0] count_one,
    output logic [3:0] count_ten,
    output logic [3:0] count_hundred,
    output logic [3:0] count_thousand,
    output logic       meas_done,
    output logic       err
);

    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int TW = $clog2(TRIG_CYCLES + 1);
    localparam int CW = $clog2(CYCLES_PER_MM + 1);

    if (TIMEOUT_CYCLES >= PERIOD_CYCLES - TRIG_CYCLES) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be below PERIOD_CYCLES - TRIG_CYCLES");
    end

    state_t        state_r;
    logic [PW-1:0] pcnt_r;
    logic [TW-1:0] tcnt_r;
    logic [CW-1:0] pre_r;
    logic [15:0]   count_r;
    logic [15:0]   acc_s;
    logic          trig_r;
    logic          meas_done_r;
    logic          sync_r;
    logic          echo_s;
    logic          echo_d;
    logic          rise_s;
    logic          fall_s;
    logic          period_zero_s;
    logic          acc_clr_s;
    logic          acc_inc_s;

    // Two-flop synchroniser plus a delay flop for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            sync_r <= echo;
            echo_s <= sync_r;
            echo_d <= echo_s;
        end
    end

    assign rise_s = echo_s & ~echo_d;
    assign fall_s = ~echo_s & echo_d;

    // Free-running measurement period counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt_r <= {PW{1'b0}};
        end else if (pcnt_r == PW'(PERIOD_CYCLES - 1)) begin
            pcnt_r <= {PW{1'b0}};
        end else begin
            pcnt_r <= pcnt_r + PW'(1);
        end
    end

    assign period_zero_s = (pcnt_r == {PW{1'b0}});
    assign acc_clr_s     = (state_r == ST_WAIT) && rise_s;
    assign acc_inc_s     = (state_r == ST_MEAS) && (pre_r == CW'(CYCLES_PER_MM - 1));

    bcd4_counter u_acc (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (acc_clr_s),
        .inc   (acc_inc_s),
        .value (acc_s)
    );

`ifdef ULT_TIMEOUT_EN
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    logic [OW-1:0] tocnt_r;
    logic          err_r;
`endif

    // Measurement sequencer; owns every registered output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            trig_r      <= 1'b0;
            tcnt_r      <= {TW{1'b0}};
            pre_r       <= {CW{1'b0}};
            count_r     <= 16'h0000;
            meas_done_r <= 1'b0;
`ifdef ULT_TIMEOUT_EN
            tocnt_r     <= {OW{1'b0}};
            err_r       <= 1'b0;
`endif
        end else begin
            meas_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (period_zero_s) begin
                        state_r <= ST_TRIG;
                        trig_r  <= 1'b1;
                        tcnt_r  <= {TW{1'b0}};
                    end
                end
                ST_TRIG: begin
                    if (tcnt_r == TW'(TRIG_CYCLES - 1)) begin
                        trig_r  <= 1'b0;
                        state_r <= ST_WAIT;
`ifdef ULT_TIMEOUT_EN
                        tocnt_r <= {OW{1'b0}};
`endif
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                ST_WAIT: begin
                    if (rise_s) begin
                        pre_r   <= {CW{1'b0}};
                        state_r <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    // A fall on the wrap cycle still counts the increment.
                    if (pre_r == CW'(CYCLES_PER_MM - 1)) begin
                        pre_r <= {CW{1'b0}};
                    end else begin
                        pre_r <= pre_r + CW'(1);
                    end
                    if (fall_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    count_r     <= acc_s;
                    meas_done_r <= 1'b1;
`ifdef ULT_TIMEOUT_EN
                    err_r       <= 1'b0;
`endif
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    trig_r  <= 1'b0;
                end
            endcase
`ifdef ULT_TIMEOUT_EN
            if ((state_r == ST_WAIT) || (state_r == ST_MEAS)) begin
                if (tocnt_r == OW'(TIMEOUT_CYCLES - 1)) begin
                    count_r     <= BCD_MAX;
                    err_r       <= 1'b1;
                    meas_done_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end else begin
                    tocnt_r <= tocnt_r + OW'(1);
                end
            end
`else
            // Period boundary abandons a stuck measurement; displayed digits hold.
            if (((state_r == ST_WAIT) || (state_r == ST_MEAS)) && period_zero_s) begin
                state_r <= ST_TRIG;
                trig_r  <= 1'b1;
                tcnt_r  <= {TW{1'b0}};
            end
`endif
        end
    end

    assign trig           = trig_r;
    assign meas_done      = meas_done_r;
    assign count_one      = count_r[3:0];
    assign count_ten      = count_r[7:4];
    assign count_hundred  = count_r[11:8];
    assign count_thousand = count_r[15:12];
`ifdef ULT_TIMEOUT_EN
    assign err            = err_r;
`else
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_ult_echo_ranger.sv
// Directed bench for ult_echo_ranger: two instances (70 and 1 cycles per mm) sharing one echo.
module tb_ult_echo_ranger;

    localparam int TRIG = 12;
    localparam int PER  = 10500;
    localparam int CPM  = 70;
    localparam int TMO  = 10200;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       echo = 1'b0;
    logic       trig, md, err;
    logic [3:0] c1, c10, c100, c1000;
    logic       trig2, md2, err2;
    logic [3:0] d1, d10, d100, d1000;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ult_echo_ranger #(
        .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PER), .CYCLES_PER_MM(CPM), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rstn(rstn), .echo(echo), .trig(trig),
        .count_one(c1), .count_ten(c10), .count_hundred(c100), .count_thousand(c1000),
        .meas_done(md), .err(err)
    );

    ult_echo_ranger #(
        .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PER), .CYCLES_PER_MM(1), .TIMEOUT_CYCLES(TMO)
    ) dut_mm1 (
        .clk(clk), .rstn(rstn), .echo(echo), .trig(trig2),
        .count_one(d1), .count_ten(d10), .count_hundred(d100), .count_thousand(d1000),
        .meas_done(md2), .err(err2)
    );

    function automatic int digits1();
        return int'({c1000, c100, c10, c1});
    endfunction

    function automatic int digits2();
        return int'({d1000, d100, d10, d1});
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for trig to reach a level; returns cycles waited.
    task automatic wait_trig(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (trig !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_trig_lvl"}, int'(trig), int'(lvl));
    endtask

    // One full measurement: trigger, echo of given width, result check.
    task automatic measure(input int width, input int exp1, input int exp2, input string tag);
        int hi = 0;
        int lat = 0;
        wait_trig(1'b1, PER + 50, {tag, "_rise"});
        while (trig === 1'b1 && hi < TRIG + 10) begin
            @(negedge clk);
            hi++;
        end
        chk({tag, "_trig_width"}, hi, TRIG);
        repeat (3) @(negedge clk);
        echo = 1'b1;
        repeat (width) @(negedge clk);
        echo = 1'b0;
        while (!md && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_digits"}, digits1(), exp1);
        chk({tag, "_digits_mm1"}, digits2(), exp2);
        chk({tag, "_err"}, int'(err), 0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, int'(md), 0);
    endtask

    initial begin
        int n;
        int dcount;
        int cap_dig;
        int cap_err;

        repeat (3) @(negedge clk);
        chk("rst_trig", int'(trig), 0);
        chk("rst_digits", digits1(), 16'h0000);
        chk("rst_done", int'(md), 0);
        chk("rst_err", int'(err), 0);

        rstn = 1'b1;
        @(negedge clk);
        chk("first_trig", int'(trig), 1);

        measure(7000,  16'h0100, 16'h7000, "w7000");
        measure(69,    16'h0000, 16'h0069, "w69");
        measure(70,    16'h0001, 16'h0070, "w70");
        measure(10050, 16'h0143, 16'h9999, "w10050");

        // No echo this period: observe rise-to-rise spacing and any result.
        wait_trig(1'b1, PER + 50, "noecho_rise");
        n = 0;
        dcount = 0;
        cap_dig = digits1();
        cap_err = int'(err);
        while (trig === 1'b1 && n < TRIG + 10) begin
            @(negedge clk);
            n++;
        end
        while (trig === 1'b0 && n < PER + 50) begin
            @(negedge clk);
            n++;
            if (md) begin
                dcount++;
                cap_dig = digits1();
                cap_err = int'(err);
            end
        end
        chk("noecho_period", n, PER);
`ifdef ULT_TIMEOUT_EN
        chk("timeout_done_cnt", dcount, 1);
        chk("timeout_digits", cap_dig, 16'h9999);
        chk("timeout_err", cap_err, 1);
`else
        chk("noecho_done_cnt", dcount, 0);
        chk("noecho_hold", digits1(), 16'h0143);
        chk("noecho_err", int'(err), 0);
`endif

        measure(7000, 16'h0100, 16'h7000, "after");

        // Reset in the middle of a measurement.
        wait_trig(1'b1, PER + 50, "rst_mid_rise");
        wait_trig(1'b0, TRIG + 10, "rst_mid_fall");
        repeat (3) @(negedge clk);
        echo = 1'b1;
        repeat (200) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_trig", int'(trig), 0);
        chk("midrst_digits", digits1(), 16'h0000);
        chk("midrst_digits_mm1", digits2(), 16'h0000);
        chk("midrst_done", int'(md), 0);
        chk("midrst_err", int'(err), 0);
        echo = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_trig_held", int'(trig), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_first_trig", int'(trig), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
